box_collect: RTL and testbench
==============================

Name: box_collect

Overview:
Producer side of the box-overlay interface. It accumulates one bounding box per blob label from the labelled pixel stream over one frame. At frame end it writes the whole box table to the overlay drawer over the bl_en/bl_addr/xy write port and publishes the active box count on bl_cnt. It sits between the connected-component labeller and the box drawer in the video path.

Parameters:
SIZE, 20, highest box index stored; table holds SIZE+1 entries (indices 0..SIZE)
CW, 10, coordinate width (x, y and each xy field)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
new_pix  in  1  pixel strobe; x, y, obj, label valid when high
x  in  CW  pixel column
y  in  CW  pixel row
obj  in  1  pixel is foreground of blob "label"
label  in  8  blob label of current pixel
frame_end  in  1  one-cycle pulse after last pixel of frame
bl_en  out  1  box write strobe to drawer
bl_addr  out  8  box index being written
xy  out  4*CW  box data: [9:0]=x0, [19:10]=y0, [29:20]=xn, [39:30]=yn (CW=10)
bl_cnt  out  8  number of box slots in use (max label seen + 1, saturated at SIZE+1)
busy  out  1  high while dumping
ovf  out  1  previous frame had a label > SIZE

Behaviour:
- Reset (async, any state): bl_en=0, bl_addr=0, xy=0, bl_cnt=0, busy=0, ovf=0. All entry valid bits are cleared, the frame count is cleared, the overflow accumulator is cleared, and the state goes to COLLECT. A dump in progress is aborted with no further bl_en.
- Table: SIZE+1 entries, each {valid, x0, y0, xn, yn}.
- States: COLLECT, DUMP.
- COLLECT, on new_pix && obj:
  - label > SIZE: pixel dropped; set the overflow accumulator.
  - Entry invalid: load x0=xn=x and y0=yn=y; set valid.
  - Entry valid: x0=min(x0,x), xn=max(xn,x), y0=min(y0,y), yn=max(yn,y). Compares are unsigned, CW bits.
  - The frame count is updated to max(count, label+1) and saturates at SIZE+1.
  - Pixels with obj=0 have no effect.
  - Back-to-back new_pix to the same label on consecutive cycles must accumulate correctly; no pixel may be lost to read-modify-write hazards.
- COLLECT, frame_end: go to DUMP with the address counter at 0. If new_pix arrives in the same cycle, that pixel is applied before the dump and appears in the dumped data.
- DUMP (busy=1): one write per cycle for addresses 0..SIZE, in order, with no gaps.
  - bl_en=1 and bl_addr=index.
  - xy = packed entry if valid, else all zeros. The drawer treats all-zero as empty.
  - The first bl_en is registered, asserted the cycle after frame_end. The dump lasts SIZE+1 cycles.
- DUMP, new_pix and frame_end are ignored. The frame has ended; these are blanking-interval pixels.
- Dump end, the cycle after the last write:
  - bl_en=0, busy=0.
  - bl_cnt <= frame count; ovf <= overflow accumulator.
  - Clear all valid bits, the frame count and the overflow accumulator.
  - Return to COLLECT.
  - bl_cnt and ovf hold their values until the next dump end.
- bl_cnt therefore changes only after all SIZE+1 entries are written, so the drawer never uses a count ahead of its data.
- A blob consisting only of pixel (0,0) packs to zero and is invisible to the drawer. This is accepted behaviour.
- bl_addr and xy hold their last values when bl_en=0.

Test Plan:
- Label 0 pixels at (5,7), (12,7), (8,20), then frame_end -> 21 consecutive bl_en pulses, bl_addr 0..20. Addr 0 xy has x0=5, y0=7, xn=12, yn=20; addrs 1..20 xy=0. Afterwards bl_cnt=1, ovf=0.
- Labels 0 at (1,1) and 3 at (100,50),(90,60) -> addr 3 xy has x0=90, y0=50, xn=100, yn=60; addrs 1,2 zero; bl_cnt=4.
- Label 25 pixel plus label 2 pixel -> label 25 absent from the dump, bl_cnt=3, ovf=1. Next frame with no overflow -> ovf=0.
- new_pix for label 0 at (300,200) in the same cycle as frame_end, with prior label 0 box x0=10, y0=10, xn=20, yn=20 -> dumped box has xn=300, yn=200.
- Reset asserted on the 5th dump cycle -> bl_en=0 immediately, bl_cnt=0, busy=0. The next frame dumps only its own boxes.
- new_pix during DUMP at label 0 (0,0) -> ignored. Next frame with no pixels -> all 21 entries zero, bl_cnt=0.

Source files
------------

// File: rtl/box_collect.sv
// Per-label bounding-box accumulator for one frame.
// At frame end the box table is dumped to the overlay drawer.
module box_collect #(
  parameter int SIZE = 20,
  parameter int CW   = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            new_pix,
  input  logic [CW-1:0]   x,
  input  logic [CW-1:0]   y,
  input  logic            obj,
  input  logic [7:0]      label,
  input  logic            frame_end,
  output logic            bl_en,
  output logic [7:0]      bl_addr,
  output logic [4*CW-1:0] xy,
  output logic [7:0]      bl_cnt,
  output logic            busy,
  output logic            ovf
);

  localparam int N = SIZE + 1;
  localparam logic [7:0] LAST = 8'(SIZE);

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_DUMP    = 1'b1;

  logic [0:0]    state;
  logic [N-1:0]  vld, vld_n;
  logic [CW-1:0] x0 [N];
  logic [CW-1:0] y0 [N];
  logic [CW-1:0] xn [N];
  logic [CW-1:0] yn [N];
  logic [CW-1:0] x0_n [N];
  logic [CW-1:0] y0_n [N];
  logic [CW-1:0] xn_n [N];
  logic [CW-1:0] yn_n [N];
  logic [7:0]    cnt, cnt_n;
  logic [7:0]    addr, addr_n;
  logic          ovf_acc;
  logic          hit;
  logic          drop;
  logic [8:0]    lbl_p1;
  logic [4*CW-1:0] rd_xy;

  assign busy   = state;
  assign hit    = (state == S_COLLECT) && new_pix && obj && (label <= LAST);
  assign drop   = (state == S_COLLECT) && new_pix && obj && (label > LAST);
  assign lbl_p1 = {1'b0, label} + 9'd1;
  assign addr_n = (state == S_COLLECT) ? 8'd0 : addr + 8'd1;
  assign cnt_n  = (hit && (lbl_p1 > {1'b0, cnt})) ? lbl_p1[7:0] : cnt;

  // Next-state table with the current pixel merged in; the dump read
  // uses it so a pixel arriving with frame_end is already visible.
  always_comb begin
    vld_n = vld;
    rd_xy = '0;
    for (int i = 0; i < N; i++) begin
      x0_n[i] = x0[i];
      y0_n[i] = y0[i];
      xn_n[i] = xn[i];
      yn_n[i] = yn[i];
      if (hit && (label == 8'(i))) begin
        vld_n[i] = 1'b1;
        if (!vld[i]) begin
          x0_n[i] = x;
          xn_n[i] = x;
          y0_n[i] = y;
          yn_n[i] = y;
        end else begin
          if (x < x0[i]) x0_n[i] = x;
          if (x > xn[i]) xn_n[i] = x;
          if (y < y0[i]) y0_n[i] = y;
          if (y > yn[i]) yn_n[i] = y;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if ((addr_n == 8'(i)) && vld_n[i])
        rd_xy = {yn_n[i], xn_n[i], y0_n[i], x0_n[i]};
    end
  end

  always_ff @(posedge clk) begin
    x0 <= x0_n;
    y0 <= y0_n;
    xn <= xn_n;
    yn <= yn_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_COLLECT;
      vld     <= '0;
      cnt     <= 8'd0;
      ovf_acc <= 1'b0;
      addr    <= 8'd0;
      bl_en   <= 1'b0;
      bl_addr <= 8'd0;
      xy      <= '0;
      bl_cnt  <= 8'd0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          vld <= vld_n;
          cnt <= cnt_n;
          if (drop) ovf_acc <= 1'b1;
          if (frame_end) begin
            state   <= S_DUMP;
            addr    <= 8'd0;
            bl_en   <= 1'b1;
            bl_addr <= 8'd0;
            xy      <= rd_xy;
          end
        end
        default: begin
          if (addr == LAST) begin
            state   <= S_COLLECT;
            bl_en   <= 1'b0;
            bl_cnt  <= cnt;
            ovf     <= ovf_acc;
            vld     <= '0;
            cnt     <= 8'd0;
            ovf_acc <= 1'b0;
          end else begin
            addr    <= addr_n;
            bl_addr <= addr_n;
            xy      <= rd_xy;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_box_collect.sv
// Directed bench for box_collect: box accumulation, dump sequencing,
// overflow, same-cycle frame_end pixel, mid-dump reset, blanking pixels.
module tb_box_collect;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_pix;
  logic [9:0]  x, y;
  logic        obj;
  logic [7:0]  label;
  logic        frame_end;
  logic        bl_en;
  logic [7:0]  bl_addr;
  logic [39:0] xy;
  logic [7:0]  bl_cnt;
  logic        busy;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_t [21];

  box_collect #(.SIZE(20), .CW(10)) dut (
    .clk(clk), .reset(reset), .new_pix(new_pix), .x(x), .y(y),
    .obj(obj), .label(label), .frame_end(frame_end),
    .bl_en(bl_en), .bl_addr(bl_addr), .xy(xy), .bl_cnt(bl_cnt),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] pk(input int ax0, input int ay0,
                                     input int axn, input int ayn);
    return {10'(ayn), 10'(axn), 10'(ay0), 10'(ax0)};
  endfunction

  task automatic chk(input string tag, input logic [39:0] got,
                     input logic [39:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 21; i++) exp_t[i] = '0;
  endtask

  // Caller is at a negedge; pixel is captured at the next posedge.
  task automatic pix(input int lb, input int px, input int py);
    new_pix = 1'b1;
    obj     = 1'b1;
    label   = 8'(lb);
    x       = 10'(px);
    y       = 10'(py);
    @(negedge clk);
    new_pix = 1'b0;
    obj     = 1'b0;
  endtask

  task automatic dump(input int ecnt, input logic eovf, input bit noise);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    new_pix   = 1'b0;
    obj       = 1'b0;
    chk("busy_dump", 40'(busy), 40'(1));
    for (int k = 0; k < 21; k++) begin
      if (noise) begin
        new_pix   = 1'b1;
        obj       = 1'b1;
        label     = (k % 2) ? 8'd5 : 8'd0;
        x         = (k % 2) ? 10'd33 : 10'd0;
        y         = (k % 2) ? 10'd44 : 10'd0;
        frame_end = (k == 10);
      end
      chk($sformatf("en[%0d]", k), 40'(bl_en), 40'(1));
      chk($sformatf("addr[%0d]", k), 40'(bl_addr), 40'(k));
      chk($sformatf("xy[%0d]", k), xy, exp_t[k]);
      @(negedge clk);
    end
    new_pix   = 1'b0;
    obj       = 1'b0;
    frame_end = 1'b0;
    chk("en_end", 40'(bl_en), 40'(0));
    chk("busy_end", 40'(busy), 40'(0));
    chk("cnt", 40'(bl_cnt), 40'(ecnt));
    chk("ovf", 40'(ovf), 40'(eovf));
    clr_exp();
  endtask

  initial begin
    reset = 1'b1; new_pix = 1'b0; obj = 1'b0; label = '0;
    x = '0; y = '0; frame_end = 1'b0;
    clr_exp();
    @(negedge clk);
    @(negedge clk);
    chk("rst_en", 40'(bl_en), 40'(0));
    chk("rst_addr", 40'(bl_addr), 40'(0));
    chk("rst_xy", xy, 40'(0));
    chk("rst_cnt", 40'(bl_cnt), 40'(0));
    chk("rst_busy", 40'(busy), 40'(0));
    chk("rst_ovf", 40'(ovf), 40'(0));
    reset = 1'b0;
    @(negedge clk);

    // back-to-back pixels on label 0
    pix(0, 5, 7); pix(0, 12, 7); pix(0, 8, 20);
    exp_t[0] = pk(5, 7, 12, 20);
    dump(1, 1'b0, 1'b0);

    pix(0, 1, 1); pix(3, 100, 50); pix(3, 90, 60);
    exp_t[0] = pk(1, 1, 1, 1);
    exp_t[3] = pk(90, 50, 100, 60);
    dump(4, 1'b0, 1'b0);

    pix(25, 4, 4); pix(2, 3, 3);
    exp_t[2] = pk(3, 3, 3, 3);
    dump(3, 1'b1, 1'b0);

    // pixel arriving with frame_end; ovf clears after a clean frame
    pix(0, 10, 10); pix(0, 20, 20);
    new_pix = 1'b1; obj = 1'b1; label = 8'd0; x = 10'd300; y = 10'd200;
    exp_t[0] = pk(10, 10, 300, 200);
    dump(1, 1'b0, 1'b0);

    // reset on the 5th dump cycle
    pix(1, 7, 8);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("pre_rst_addr", 40'(bl_addr), 40'(4));
    reset = 1'b1;
    #1;
    chk("mid_rst_en", 40'(bl_en), 40'(0));
    chk("mid_rst_busy", 40'(busy), 40'(0));
    chk("mid_rst_cnt", 40'(bl_cnt), 40'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_en", 40'(bl_en), 40'(0));
    pix(4, 9, 9);
    exp_t[4] = pk(9, 9, 9, 9);
    dump(5, 1'b0, 1'b0);

    // empty frame with blanking pixels and a stray frame_end in the dump
    dump(0, 1'b0, 1'b1);
    dump(0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
